fft_map_sequencer: RTL and testbench



---
 rtl/fft_map_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fft_map_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fft_map_sequencer.sv
// Control FSM for the 32-point iterative FFT: sequences input capture, five
// radix-2 butterfly stages and output capture, with start/done handshake and stall.
module fft_map_sequencer #(
    parameter int unsigned BF_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stall,
    input  logic       out_ready,
    output logic [2:0] sel_mapping,
    output logic [2:0] stage_idx,
    output logic       bf_en,
    output logic       reg_load_en,
    output logic       reg_src_sel,
    output logic       busy,
    output logic       out_valid
);

    localparam int unsigned CYC_W = 4;
    localparam int unsigned STG_W = 3;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BF_LAT - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(4);
    localparam logic [2:0] SEL_INPUT  = 3'b000;
    localparam logic [2:0] SEL_OUTPUT = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STAGE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [STG_W-1:0] s_q, s_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;

    logic [2:0] sel_mapping_q, sel_mapping_d;
    logic [2:0] stage_idx_q, stage_idx_d;
    logic       bf_en_q, bf_en_d;
    logic       reg_load_en_q, reg_load_en_d;
    logic       reg_src_sel_q, reg_src_sel_d;
    logic       busy_q, busy_d;
    logic       out_valid_q, out_valid_d;

    // Next state and counters; a stall freezes everything in place.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cyc_d   = cyc_q;
        if (!stall) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_d = S_STAGE;
                    s_d     = '0;
                    cyc_d   = '0;
                end
                S_STAGE: begin
                    if (cyc_q == CYC_LAST) begin
                        cyc_d = '0;
                        if (s_q == STG_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            s_d = s_q + STG_W'(1);
                        end
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                        s_d     = '0;
                        cyc_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        sel_mapping_d = SEL_INPUT;
        stage_idx_d   = '0;
        bf_en_d       = 1'b0;
        reg_load_en_d = 1'b0;
        reg_src_sel_d = 1'b0;
        busy_d        = 1'b0;
        out_valid_d   = 1'b0;
        case (state_d)
            S_LOAD: begin
                reg_load_en_d = 1'b1;
                busy_d        = 1'b1;
            end
            S_STAGE: begin
                sel_mapping_d = s_d + 3'd1;
                stage_idx_d   = s_d;
                bf_en_d       = 1'b1;
                reg_load_en_d = (cyc_d == CYC_LAST);
                reg_src_sel_d = 1'b1;
                busy_d        = 1'b1;
            end
            S_DONE: begin
                sel_mapping_d = SEL_OUTPUT;
                stage_idx_d   = STG_LAST;
                out_valid_d   = 1'b1;
            end
            default: begin
            end
        endcase
        if (stall) begin
            sel_mapping_d = sel_mapping_q;
            stage_idx_d   = stage_idx_q;
            reg_src_sel_d = reg_src_sel_q;
            busy_d        = busy_q;
            out_valid_d   = out_valid_q;
            bf_en_d       = 1'b0;
            reg_load_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            s_q           <= '0;
            cyc_q         <= '0;
            sel_mapping_q <= SEL_INPUT;
            stage_idx_q   <= '0;
            bf_en_q       <= 1'b0;
            reg_load_en_q <= 1'b0;
            reg_src_sel_q <= 1'b0;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            cyc_q         <= cyc_d;
            sel_mapping_q <= sel_mapping_d;
            stage_idx_q   <= stage_idx_d;
            bf_en_q       <= bf_en_d;
            reg_load_en_q <= reg_load_en_d;
            reg_src_sel_q <= reg_src_sel_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign sel_mapping = sel_mapping_q;
    assign stage_idx   = stage_idx_q;
    assign bf_en       = bf_en_q;
    assign reg_load_en = reg_load_en_q;
    assign reg_src_sel = reg_src_sel_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_fft_map_sequencer.sv
// Directed bench for fft_map_sequencer: BF_LAT=2 sequencing, stall, DONE hold,
// mid-transform reset, back-to-back starts, plus BF_LAT=1/15 latency instances.
module tb_fft_map_sequencer;

    logic clk = 1'b0;
    logic rst_n, start, stall, out_ready;

    logic [2:0] sel2, stg2, sel1, stg1, sel15, stg15;
    logic bf2, ld2, src2, busy2, ov2;
    logic bf1, ld1, src1, busy1, ov1;
    logic bf15, ld15, src15, busy15, ov15;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fft_map_sequencer #(.BF_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .out_ready(out_ready),
        .sel_mapping(sel2), .stage_idx(stg2), .bf_en(bf2), .reg_load_en(ld2),
        .reg_src_sel(src2), .busy(busy2), .out_valid(ov2)
    );
    fft_map_sequencer #(.BF_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .out_ready(out_ready),
        .sel_mapping(sel1), .stage_idx(stg1), .bf_en(bf1), .reg_load_en(ld1),
        .reg_src_sel(src1), .busy(busy1), .out_valid(ov1)
    );
    fft_map_sequencer #(.BF_LAT(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .out_ready(out_ready),
        .sel_mapping(sel15), .stage_idx(stg15), .bf_en(bf15), .reg_load_en(ld15),
        .reg_src_sel(src15), .busy(busy15), .out_valid(ov15)
    );

    // {sel_mapping, stage_idx, bf_en, reg_load_en, reg_src_sel, busy, out_valid}
    logic [10:0] obs;
    assign obs = {sel2, stg2, bf2, ld2, src2, busy2, ov2};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected output vector in cycle k (k=1 is the cycle after start is sampled), no stalls.
    function automatic logic [10:0] nominal(input int k, input int lat);
        logic [2:0] sel, stg;
        logic bf, ld, src, bsy, ov;
        int s, c;
        sel = 3'd0; stg = 3'd0; bf = 1'b0; ld = 1'b0; src = 1'b0; bsy = 1'b0; ov = 1'b0;
        if (k == 1) begin
            ld = 1'b1; bsy = 1'b1;
        end else if (k >= 2 && k <= 1 + 5 * lat) begin
            s = (k - 2) / lat;
            c = (k - 2) % lat;
            sel = 3'(s + 1); stg = 3'(s); bf = 1'b1; src = 1'b1; bsy = 1'b1;
            ld = (c == lat - 1);
        end else if (k == 2 + 5 * lat) begin
            sel = 3'd5; stg = 3'd4; ov = 1'b1;
        end
        return {sel, stg, bf, ld, src, bsy, ov};
    endfunction

    logic [10:0] frz;
    int loads, first1, first2, first15, bfc1, bfc15;

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; out_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        check_eq("reset_outputs", 32'(obs), 32'd0);

        // All three latencies run one transform together.
        start = 1'b1;
        step();
        start = 1'b0;
        first1 = 0; first2 = 0; first15 = 0; bfc1 = 0; bfc15 = 0; loads = 0;
        for (int k = 1; k <= 85; k++) begin
            if (ov1 && first1 == 0) first1 = k;
            if (ov2 && first2 == 0) first2 = k;
            if (ov15 && first15 == 0) first15 = k;
            if (bf1) bfc1++;
            if (bf15) bfc15++;
            if (k <= 14) begin
                check_eq($sformatf("seq_k%0d", k), 32'(obs), 32'(nominal(k, 2)));
                if (ld2) loads++;
            end
            step();
        end
        check_eq("lat2_loads", 32'(loads), 32'd6);
        check_eq("lat2_ov_cycle", 32'(first2), 32'd12);
        check_eq("lat1_ov_cycle", 32'(first1), 32'd7);
        check_eq("lat15_ov_cycle", 32'(first15), 32'd77);
        check_eq("lat1_bf_cycles", 32'(bfc1), 32'd5);
        check_eq("lat15_bf_cycles", 32'(bfc15), 32'd75);
        check_eq("idle_after_run", 32'(obs), 32'd0);

        // Stall in cycles 4..6: frozen, no strobes for three cycles, DONE at 15.
        start = 1'b1;
        step();
        start = 1'b0;
        frz = nominal(4, 2) & 11'b111_111_0_0_1_1_1;
        for (int k = 1; k <= 17; k++) begin
            if (k <= 4)
                check_eq($sformatf("stall_k%0d", k), 32'(obs), 32'(nominal(k, 2)));
            else if (k <= 7)
                check_eq($sformatf("stall_k%0d", k), 32'(obs), 32'(frz));
            else
                check_eq($sformatf("stall_k%0d", k), 32'(obs), 32'(nominal(k - 3, 2)));
            stall = (k >= 4 && k <= 6);
            step();
        end
        stall = 1'b0;

        // DONE held while out_ready low; a start during DONE is dropped.
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 2; k <= 12; k++) step();
        check_eq("hold_done_entry", 32'(obs), 32'(nominal(12, 2)));
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            step();
            check_eq($sformatf("hold_done_%0d", i), 32'(obs), 32'(nominal(12, 2)));
        end
        start = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("done_to_idle", 32'(obs), 32'd0);
        step();
        check_eq("start_not_queued", 32'(obs), 32'd0);

        // Reset during stage 2 aborts the transform; a new one runs completely.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 2; k <= 6; k++) step();
        check_eq("pre_reset_k6", 32'(obs), 32'(nominal(6, 2)));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("mid_reset_k7", 32'(obs), 32'd0);
        step();
        check_eq("post_reset_idle", 32'(obs), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        loads = 0;
        for (int k = 1; k <= 13; k++) begin
            check_eq($sformatf("rerun_k%0d", k), 32'(obs), 32'(nominal(k, 2)));
            if (ld2) loads++;
            step();
        end
        check_eq("rerun_loads", 32'(loads), 32'd6);

        // start held high: 12 active cycles then exactly one IDLE cycle, repeating.
        start = 1'b1;
        step();
        for (int k = 1; k <= 39; k++) begin
            check_eq($sformatf("b2b_k%0d", k), 32'(obs), 32'(nominal(((k - 1) % 13) + 1, 2)));
            check_eq($sformatf("b2b_excl_k%0d", k), 32'(busy2 & ov2), 32'd0);
            step();
        end
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
